// File: rtl/matmac_stream.sv
// Streaming N x N signed matrix multiply-accumulate, Co = A*B + C, one MAC.
// Optional macro SATURATE_EN: clamp results to DW bits and raise sticky ovf.
`timescale 1ns/1ps
module matmac_stream #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    localparam int IW = $clog2(N);
    localparam int KW = $clog2(N + 1);
    localparam int AW = 2 * DW + $clog2(N) + 1;
    localparam logic [IW-1:0] LAST  = IW'(N - 1);
    localparam logic [KW-1:0] KLAST = KW'(N);

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMP,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [DW-1:0] r_a [N][N];
    logic signed [DW-1:0] r_b [N][N];
    logic signed [DW-1:0] r_c [N][N];
    logic signed [DW-1:0] r_r [N][N];

    logic [1:0]    r_lm;
    logic [IW-1:0] r_lr;
    logic [IW-1:0] r_lc;
    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic [KW-1:0] r_k;
    logic [IW-1:0] r_or;
    logic [IW-1:0] r_oc;
    logic signed [AW-1:0] r_acc;
    logic          r_done;

    logic                   w_accept;
    logic                   w_load_last;
    logic                   w_elem_end;
    logic                   w_comp_last;
    logic                   w_out_hs;
    logic                   w_drain_last;
    logic [IW-1:0]          w_kidx;
    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]   w_sum;
    logic signed [AW-1:0]   w_cext;
    logic [DW-1:0]          w_red;

    assign w_accept     = in_valid && (r_state == S_LOAD);
    assign w_load_last  = w_accept && (r_lm == 2'd2)
                          && (r_lr == LAST) && (r_lc == LAST);
    assign w_elem_end   = (r_state == S_COMP) && (r_k == KLAST);
    assign w_comp_last  = w_elem_end && (r_i == LAST) && (r_j == LAST);
    assign w_out_hs     = (r_state == S_DRAIN) && out_ready;
    assign w_drain_last = w_out_hs && (r_or == LAST) && (r_oc == LAST);

    // MAC cycle k (1..N) consumes term k-1
    assign w_kidx = IW'(r_k - KW'(1));
    assign w_prod = r_a[r_i][w_kidx] * r_b[w_kidx][r_j];
    assign w_sum  = r_acc + {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_cext = {{(AW-DW){r_c[r_i][r_j][DW-1]}}, r_c[r_i][r_j]};

`ifdef SATURATE_EN
    logic w_clip;
    logic r_ovf;

    // Fits in DW bits only when all bits above the DW sign bit agree
    assign w_clip = !(&w_sum[AW-1:DW-1]) && (|w_sum[AW-1:DW-1]);

    always_comb begin
        w_red = w_sum[DW-1:0];
        if (w_clip) begin
            w_red = w_sum[AW-1] ? {1'b1, {(DW-1){1'b0}}}
                                : {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept && (r_lm == 2'd0)
                     && (r_lr == '0) && (r_lc == '0)) begin
            r_ovf <= 1'b0;
        end else if (w_elem_end && w_clip) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_red = w_sum[DW-1:0];
    assign ovf   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (w_load_last) begin
                    w_next = S_COMP;
                end
            end
            S_COMP: begin
                busy = 1'b1;
                if (w_comp_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_r[r_or][r_oc];
                if (w_drain_last) begin
                    w_next = S_LOAD;
                end
            end
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lm   <= '0;
            r_lr   <= '0;
            r_lc   <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
            r_or   <= '0;
            r_oc   <= '0;
            r_acc  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_drain_last;
            if (w_accept) begin
                if (r_lc == LAST) begin
                    r_lc <= '0;
                    if (r_lr == LAST) begin
                        r_lr <= '0;
                        r_lm <= (r_lm == 2'd2) ? 2'd0 : r_lm + 2'd1;
                    end else begin
                        r_lr <= r_lr + IW'(1);
                    end
                end else begin
                    r_lc <= r_lc + IW'(1);
                end
            end
            if (r_state == S_COMP) begin
                r_acc <= (r_k == '0) ? w_cext : w_sum;
                if (r_k == KLAST) begin
                    r_k <= '0;
                    if (r_j == LAST) begin
                        r_j <= '0;
                        r_i <= (r_i == LAST) ? '0 : r_i + IW'(1);
                    end else begin
                        r_j <= r_j + IW'(1);
                    end
                end else begin
                    r_k <= r_k + KW'(1);
                end
            end
            if (w_out_hs) begin
                if (r_oc == LAST) begin
                    r_oc <= '0;
                    r_or <= (r_or == LAST) ? '0 : r_or + IW'(1);
                end else begin
                    r_oc <= r_oc + IW'(1);
                end
            end
        end
    end

    // Operand and result buffers hold don't-care data after reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            case (r_lm)
                2'd0:    r_a[r_lr][r_lc] <= in_data;
                2'd1:    r_b[r_lr][r_lc] <= in_data;
                default: r_c[r_lr][r_lc] <= in_data;
            endcase
        end
        if (w_elem_end) begin
            r_r[r_i][r_j] <= w_red;
        end
    end

    assign done = r_done;

endmodule

// File: tb/tb_matmac_stream.sv
// Directed bench for matmac_stream: N=2 jobs at DW=32 plus a DW=8 overflow job.
`timescale 1ns/1ps
module tb_matmac_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        ovf;

    logic        in8_valid;
    logic        in8_ready;
    logic [7:0]  in8_data;
    logic        out8_valid;
    logic        out8_ready;
    logic [7:0]  out8_data;
    logic        busy8;
    logic        done8;
    logic        ovf8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matmac_stream #(.N(2), .DW(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    matmac_stream #(.N(2), .DW(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in8_valid),
        .in_ready  (in8_ready),
        .in_data   (in8_data),
        .out_valid (out8_valid),
        .out_ready (out8_ready),
        .out_data  (out8_data),
        .busy      (busy8),
        .done      (done8),
        .ovf       (ovf8)
    );

    typedef struct packed {
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [3:0][31:0] c;
        logic [3:0][31:0] e;
        logic             eovf;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [3:0][31:0] pk(input int x0, input int x1,
                                            input int x2, input int x3);
        logic [3:0][31:0] r;
        r[0] = x0;
        r[1] = x1;
        r[2] = x2;
        r[3] = x3;
        return r;
    endfunction

    function automatic logic [31:0] word(input vec_t v, input int w);
        if (w < 4) return v.a[w];
        if (w < 8) return v.b[w-4];
        return v.c[w-8];
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     nm, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic load_words(input int v, input int nw);
        for (int w = 0; w < nw; w++) begin
            in_valid = 1'b1;
            in_data  = word(vecs[v], w);
            @(posedge clk);
            #1;
            if (w == 0) check("done_one_cycle", done, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int v, input bit hold, input bit bp);
        int cnt;
        load_words(v, 12);
        in_valid = hold;
        in_data  = 32'hDEADBEEF;
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            if (hold) check("ignored_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            cnt++;
        end
        check("latency_edges", cnt, 12);
        if (bp) begin
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                check("bp_valid", out_valid, 1);
                check("bp_data_hold", out_data, vecs[v].e[0]);
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        for (int o = 0; o < 4; o++) begin
            check("out_valid", out_valid, 1);
            check("out_data", out_data, vecs[v].e[o]);
            if (hold) check("ignored_in_ready_drain", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("done_pulse", done, 1);
        check("done_in_ready", in_ready, 1);
        check("done_busy", busy, 0);
        check("done_out_valid", out_valid, 0);
        check("job_ovf", ovf, vecs[v].eovf);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [7:0] e8;
        logic       eovf8;

        vecs[0] = '{a: pk(1, 2, 3, 4), b: pk(5, 6, 7, 8),
                    c: pk(1, 1, 1, 1), e: pk(20, 23, 44, 51), eovf: 1'b0};
        vecs[1] = '{a: pk(-1, 0, 0, -1), b: pk(3, -4, 5, 6),
                    c: pk(0, 0, 0, 0), e: pk(-3, 4, -5, -6), eovf: 1'b0};
`ifdef SATURATE_EN
        vecs[2] = '{a: pk(65536, 0, 0, 0), b: pk(65536, 0, 0, 0),
                    c: pk(5, 0, 0, 0), e: pk(32'h7fffffff, 0, 0, 0),
                    eovf: 1'b1};
        e8    = 8'd127;
        eovf8 = 1'b1;
`else
        vecs[2] = '{a: pk(65536, 0, 0, 0), b: pk(65536, 0, 0, 0),
                    c: pk(5, 0, 0, 0), e: pk(5, 0, 0, 0), eovf: 1'b0};
        e8    = 8'd32;
        eovf8 = 1'b0;
`endif
        vecs[3] = '{a: pk(2, -3, 7, 0), b: pk(-1, 4, 2, 5),
                    c: pk(10, -20, 0, 100), e: pk(2, -27, -7, 128),
                    eovf: 1'b0};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in8_valid  = 1'b0;
        in8_data   = '0;
        out8_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk);
        #1;

        for (int v = 0; v < 4; v++) run_job(v, 1'b0, 1'b0);

        run_job(0, 1'b0, 1'b1);

        // Reset five edges into COMP
        load_words(0, 12);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_job(0, 1'b0, 1'b0);

        // Partial load discarded by reset
        load_words(3, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_job(1, 1'b0, 1'b0);

        // Ignored input while busy, then back-to-back jobs from done cycle
        run_job(3, 1'b1, 1'b0);
        run_job(0, 1'b0, 1'b0);
        run_job(1, 1'b0, 1'b0);

        // DW=8 overflow job: all A=B=100, C=0
        for (int w = 0; w < 12; w++) begin
            in8_valid = 1'b1;
            in8_data  = (w < 8) ? 8'd100 : 8'd0;
            @(posedge clk);
            #1;
        end
        in8_valid = 1'b0;
        cnt = 0;
        while (!out8_valid && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("dw8_latency", cnt, 12);
        out8_ready = 1'b1;
        for (int o = 0; o < 4; o++) begin
            check("dw8_valid", out8_valid, 1);
            check("dw8_data", {24'd0, out8_data}, {24'd0, e8});
            @(posedge clk);
            #1;
        end
        out8_ready = 1'b0;
        check("dw8_done", done8, 1);
        check("dw8_ovf", ovf8, eovf8);
        check("dw8_busy", busy8, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
